alu_operand_sequencer: RTL and testbench

- Upstream/downstream companion to the adder/subtractor.
- Holds the accumulator (A) and B operand registers and loads them from the shared data bus via a valid/ready handshake.
- Drives the adder's A_in/B_in/SUB/OE, then captures the adder's sum and carry back into the accumulator and a flags register.
- Sequences one add/subtract per start request; signals completion with a one-cycle done pulse.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_flags_reg.sv | 60 ++++++
 rtl/alu_operand_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_operand_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// Holds the sequencer state encoding, the default datapath width and the flag bit positions.
// Optional overflow flag support is controlled by ALU_SEQ_OVF_EN.
package alu_seq_pkg;

  localparam int ALU_SEQ_WIDTH = 8;

  // Flag bit positions inside the flags register
  localparam int FLAG_Z_BIT = 0;
  localparam int FLAG_C_BIT = 1;
  localparam int FLAG_V_BIT = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/alu_flags_reg.sv
// Result flag register: zero, carry and (optionally) signed overflow.
// Captures on we_i at the rising edge; no flow control, always ready.
// Overflow flag and its inputs exist only when ALU_SEQ_OVF_EN is defined.
module alu_flags_reg
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = ALU_SEQ_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
`ifdef ALU_SEQ_OVF_EN
  input  logic             a_msb_i,
  input  logic             b_msb_i,
  input  logic             sub_i,
  output logic             flag_v_o,
`endif
  output logic             flag_z_o,
  output logic             flag_c_o
);

`ifdef ALU_SEQ_OVF_EN
  localparam int NFLAGS = 3;
`else
  localparam int NFLAGS = 2;
`endif

  logic [NFLAGS-1:0] flags_q;
  logic [NFLAGS-1:0] flags_d;

  // Next flag values: recompute on write, otherwise hold
  always_comb begin
    flags_d = flags_q;
    if (we_i) begin
      flags_d[FLAG_Z_BIT] = (sum_i == '0);
      flags_d[FLAG_C_BIT] = carry_i;
`ifdef ALU_SEQ_OVF_EN
      // add: operands agree in sign, result disagrees
      // sub: operands differ in sign, result disagrees with A
      flags_d[FLAG_V_BIT] = (sub_i ? (a_msb_i != b_msb_i) : (a_msb_i == b_msb_i))
                            && (sum_i[WIDTH-1] != a_msb_i);
`endif
    end
  end

  // Flag storage with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flag_z_o = flags_q[FLAG_Z_BIT];
  assign flag_c_o = flags_q[FLAG_C_BIT];
`ifdef ALU_SEQ_OVF_EN
  assign flag_v_o = flags_q[FLAG_V_BIT];
`endif

endmodule

// File: rtl/alu_operand_sequencer.sv
// Loads A/B operands from the bus, drives the external adder, writes back result and flags.
// Latency: done is high 2 edges after the edge accepting B (EXEC, WB, then DONE).
// Backpressure: bus_ready only in LOAD_A/LOAD_B, stalls indefinitely; ALU_SEQ_OVF_EN adds flag_v.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = ALU_SEQ_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             sub_req,
  input  logic             chain,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             bus_valid,
  output logic             bus_ready,
  output logic [WIDTH-1:0] A_q,
  output logic [WIDTH-1:0] B_q,
  output logic             SUB,
  output logic             OE,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
`ifdef ALU_SEQ_OVF_EN
  output logic             flag_v,
`endif
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_d, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sub_q, sub_d;
  logic             flags_we;

  // Next-state, register next values and adder/handshake controls
  always_comb begin
    state_d   = state_q;
    a_d       = A_q;
    b_d       = B_q;
    result_d  = result_q;
    sub_d     = sub_q;
    bus_ready = 1'b0;
    OE        = 1'b0;
    SUB       = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    flags_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          sub_d = sub_req;
          // chain keeps the accumulator as A, so the A load is skipped
          state_d = chain ? LOAD_B : LOAD_A;
        end
      end
      LOAD_A: begin
        bus_ready = 1'b1;
        if (bus_valid) begin
          a_d     = bus_in;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        bus_ready = 1'b1;
        if (bus_valid) begin
          b_d     = bus_in;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // one cycle for the combinational adder to settle
        OE      = 1'b1;
        SUB     = sub_q;
        state_d = WB;
      end
      WB: begin
        OE       = 1'b1;
        SUB      = sub_q;
        a_d      = sum_in;
        result_d = sum_in;
        flags_we = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      A_q      <= '0;
      B_q      <= '0;
      result_q <= '0;
      sub_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      A_q      <= a_d;
      B_q      <= b_d;
      result_q <= result_d;
      sub_q    <= sub_d;
    end
  end

  assign result = result_q;

  alu_flags_reg #(
    .WIDTH (WIDTH)
  ) u_flags (
    .CLK      (CLK),
    .RST      (RST),
    .we_i     (flags_we),
    .sum_i    (sum_in),
    .carry_i  (carry_in),
`ifdef ALU_SEQ_OVF_EN
    .a_msb_i  (A_q[WIDTH-1]),
    .b_msb_i  (B_q[WIDTH-1]),
    .sub_i    (sub_q),
    .flag_v_o (flag_v),
`endif
    .flag_z_o (flag_z),
    .flag_c_o (flag_c)
  );

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural adder model.
// Inputs change and outputs are sampled 1ns after the rising edge.
// Overflow checks are compiled in when ALU_SEQ_OVF_EN is defined.
module tb_alu_operand_sequencer;

  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic         start, sub_req, chain;
  logic [W-1:0] bus_in;
  logic         bus_valid, bus_ready;
  logic [W-1:0] A_q, B_q;
  logic         SUB, OE;
  logic [W-1:0] sum_in;
  logic         carry_in;
  logic [W-1:0] result;
  logic         flag_z, flag_c, busy, done;
`ifdef ALU_SEQ_OVF_EN
  logic         flag_v;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int done_cnt = 0;
  int snap;

  alu_operand_sequencer #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .sub_req   (sub_req),
    .chain     (chain),
    .bus_in    (bus_in),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .A_q       (A_q),
    .B_q       (B_q),
    .SUB       (SUB),
    .OE        (OE),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
`ifdef ALU_SEQ_OVF_EN
    .flag_v    (flag_v),
`endif
    .busy      (busy),
    .done      (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural adder: subtract as A + ~B + 1, carry is the bit above the MSB
  logic [W:0] add_full;
  always_comb begin
    add_full = '0;
    if (OE) begin
      if (SUB) add_full = {1'b0, A_q} + {1'b0, ~B_q} + 9'd1;
      else     add_full = {1'b0, A_q} + {1'b0, B_q};
    end
    sum_in   = add_full[W-1:0];
    carry_in = add_full[W];
  end

  always @(negedge CLK) if (done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

`ifdef ALU_SEQ_OVF_EN
  // Full non-chained operation with a bounded wait for done
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    start = 1'b1; sub_req = s; chain = 1'b0;
    step();
    start = 1'b0;
    bus_in = a; bus_valid = 1'b1;
    step();
    bus_in = b;
    step();
    bus_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("ovf_done_seen", {31'd0, done}, 32'd1);
  endtask
`endif

  initial begin
    RST = 1'b1; start = 1'b0; sub_req = 1'b0; chain = 1'b0;
    bus_in = '0; bus_valid = 1'b0;
    step();
    step();
    // reset state
    check("rst_A", A_q, 0);
    check("rst_B", B_q, 0);
    check("rst_result", result, 0);
    check("rst_flags", {flag_z, flag_c}, 0);
    check("rst_ctrl", {bus_ready, OE, SUB, busy, done}, 0);
    RST = 1'b0;
    step();

    // add 0x05 + 0x03
    start = 1'b1; sub_req = 1'b0; chain = 1'b0;
    step();
    start = 1'b0;
    check("add_loadA_ready", {busy, bus_ready, OE}, 3'b110);
    bus_in = 8'h05; bus_valid = 1'b1;
    step();
    check("add_A", A_q, 8'h05);
    check("add_loadB_ready", bus_ready, 1);
    bus_in = 8'h03;
    step();
    bus_valid = 1'b0;
    check("add_B", B_q, 8'h03);
    check("add_exec", {bus_ready, OE, SUB, done}, 4'b0100);
    step();
    check("add_wb", {OE, SUB, done}, 3'b100);
    step();
    check("add_done", {done, busy, OE}, 3'b110);
    check("add_result", result, 8'h08);
    check("add_accum", A_q, 8'h08);
    check("add_flags", {flag_z, flag_c}, 2'b00);
    step();
    check("add_idle", {done, busy}, 2'b00);

    // chain: A stays 0x08, only B is loaded
    start = 1'b1; chain = 1'b1;
    step();
    start = 1'b0; chain = 1'b0;
    check("chain_loadB_ready", {busy, bus_ready}, 2'b11);
    check("chain_A_kept", A_q, 8'h08);
    bus_in = 8'h02; bus_valid = 1'b1;
    step();
    bus_valid = 1'b0;
    check("chain_exec", {bus_ready, OE}, 2'b01);
    check("chain_flags_hold", {flag_z, flag_c}, 2'b00);
    step();
    step();
    check("chain_done", done, 1);
    check("chain_result", result, 8'h0A);
    step();

    // subtract to zero with a stall in LOAD_B and a start pulse while busy
    snap = done_cnt;
    start = 1'b1; sub_req = 1'b1;
    step();
    start = 1'b0; sub_req = 1'b0;
    bus_in = 8'h05; bus_valid = 1'b1;
    step();
    bus_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      step();
      check("stall_ready", {busy, bus_ready, OE}, 3'b110);
    end
    start = 1'b0;
    bus_in = 8'h05; bus_valid = 1'b1;
    step();
    bus_valid = 1'b0;
    check("sub_B", B_q, 8'h05);
    check("sub_exec", {OE, SUB}, 2'b11);
    step();
    check("sub_wb", {OE, SUB}, 2'b11);
    step();
    check("sub_done", done, 1);
    check("sub_result", result, 8'h00);
    check("sub_flags", {flag_z, flag_c}, 2'b11);
    // start presented in DONE is dropped
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_start_ignored", {busy, bus_ready}, 2'b00);
    step();
    check("done_start_still_idle", busy, 0);
    check("sub_one_done", done_cnt - snap, 1);

    // reset during EXEC
    snap = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    bus_in = 8'h11; bus_valid = 1'b1;
    step();
    bus_in = 8'h22;
    step();
    bus_valid = 1'b0;
    check("mid_exec", OE, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("mid_rst_regs", {A_q, B_q, result}, 0);
    check("mid_rst_flags", {flag_z, flag_c}, 0);
    check("mid_rst_ctrl", {bus_ready, OE, SUB, busy, done}, 0);
    step();
    step();
    step();
    check("mid_rst_no_done", done_cnt - snap, 0);
    check("mid_rst_idle", busy, 0);

`ifdef ALU_SEQ_OVF_EN
    check("rst_flag_v", flag_v, 0);
    run_op(1'b0, 8'h7F, 8'h01);
    check("ovf_result", result, 8'h80);
    check("ovf_v_set", flag_v, 1);
    step();
    run_op(1'b0, 8'h01, 8'h01);
    check("ovf_result2", result, 8'h02);
    check("ovf_v_clear", flag_v, 0);
    step();
    // 0x80 - 0x01: signs differ and result sign flips away from A
    run_op(1'b1, 8'h80, 8'h01);
    check("ovf_sub_result", result, 8'h7F);
    check("ovf_sub_v", flag_v, 1);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
